// File: rtl/exmem_fork_if.sv
// One hop of the 128-bit memory bus. The request goes from initiator to target.
// The response code, read data and bus exception come back from target to initiator.
interface exmem_fork_if;
    logic [127:0] out_data;
    logic [47:0]  addr_a;
    logic [47:0]  addr_b;
    logic [4:0]   opm;
    logic [127:0] in_data;
    logic [1:0]   ok;
    logic [63:0]  bus_exc;

    modport master (
        output out_data, addr_a, addr_b, opm,
        input  in_data, ok, bus_exc
    );

    modport slave (
        input  out_data, addr_a, addr_b, opm,
        output in_data, ok, bus_exc
    );
endinterface

// File: rtl/exmem_fork.sv
// Routes one upstream memory request to target 1 or 2 by AddrA decode; steers OK/data/exceptions back.
// 2 cycles each way (input reg + output reg); HOLD from target is forwarded upstream, hung target -> FAULT.
module exmem_fork #(
    parameter logic [47:0] T2_BASE = 48'hF000_0000_0000,
    parameter logic [47:0] T2_MASK = 48'hF000_0000_0000,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic         clock,
    input  logic         reset,
    exmem_fork_if.slave  mem,
    exmem_fork_if.master mem1,
    exmem_fork_if.master mem2
);
    localparam logic [1:0] OK_READY  = 2'b00;
    localparam logic [1:0] OK_HOLD   = 2'b10;
    localparam logic [1:0] OK_FAULT  = 2'b11;
    localparam logic [4:0] OPM_READY = 5'h00;

    typedef enum logic [1:0] {IDLE, FWD1, FWD2, TOUT} state_t;

    state_t state, state_nxt;

    logic [127:0] up_out_data;
    logic [47:0]  up_addr_a, up_addr_b;
    logic [4:0]   up_opm;
    logic [127:0] t1_in_data, t2_in_data;
    logic [1:0]   t1_ok, t2_ok;
    logic [63:0]  t1_exc, t2_exc;

    logic [7:0]   cnt;
    logic [47:0]  addr_lat;
    logic         pend_vld, pend_vld_nxt;
    logic [63:0]  pend_dat, pend_dat_nxt;
    logic [63:0]  exc_nxt;

    logic         dec_t2, fwd, tout_hit, take2;
    logic [1:0]   tgt_ok;

    always_ff @(posedge clock) begin
        if (!reset) begin
            up_out_data <= '0;
            up_addr_a   <= '0;
            up_addr_b   <= '0;
            up_opm      <= '0;
            t1_in_data  <= '0;
            t2_in_data  <= '0;
            t1_ok       <= '0;
            t2_ok       <= '0;
            t1_exc      <= '0;
            t2_exc      <= '0;
        end else begin
            up_out_data <= mem.out_data;
            up_addr_a   <= mem.addr_a;
            up_addr_b   <= mem.addr_b;
            up_opm      <= mem.opm;
            t1_in_data  <= mem1.in_data;
            t2_in_data  <= mem2.in_data;
            t1_ok       <= mem1.ok;
            t2_ok       <= mem2.ok;
            t1_exc      <= mem1.bus_exc;
            t2_exc      <= mem2.bus_exc;
        end
    end

    assign dec_t2   = (up_addr_a & T2_MASK) == T2_BASE;
    assign fwd      = (state == FWD1) || (state == FWD2);
    assign tgt_ok   = (state == FWD2) ? t2_ok : t1_ok;
    assign tout_hit = fwd && (cnt == TIMEOUT);
    assign take2    = t2_exc[15] && !pend_vld;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (up_opm != OPM_READY) state_nxt = dec_t2 ? FWD2 : FWD1;
            FWD1, FWD2: begin
                if (cnt == TIMEOUT)
                    state_nxt = TOUT;
                else if (up_opm == OPM_READY && tgt_ok == OK_READY)
                    state_nxt = IDLE;
            end
            TOUT: if (up_opm == OPM_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    function automatic logic [63:0] retag(input logic [63:0] e, input logic [3:0] tag);
        retag = {e[63:12], tag, e[7:0]};
    endfunction

    // Priority: timeout > target 1 > pending target 2 > fresh target 2.
    always_comb begin
        exc_nxt      = '0;
        pend_vld_nxt = pend_vld;
        pend_dat_nxt = pend_dat;
        if (tout_hit || t1_exc[15]) begin
            exc_nxt = tout_hit ? {addr_lat, 16'h8E00} : retag(t1_exc, 4'd1);
            if (take2) begin
                pend_vld_nxt = 1'b1;
                pend_dat_nxt = retag(t2_exc, 4'd2);
            end
        end else if (pend_vld) begin
            exc_nxt      = pend_dat;
            pend_vld_nxt = t2_exc[15];
            pend_dat_nxt = retag(t2_exc, 4'd2);
        end else if (t2_exc[15]) begin
            exc_nxt = retag(t2_exc, 4'd2);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_lat <= '0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
        end else begin
            state    <= state_nxt;
            pend_vld <= pend_vld_nxt;
            pend_dat <= pend_dat_nxt;
            if (state == IDLE && up_opm != OPM_READY)
                addr_lat <= up_addr_a;
            if (fwd && tgt_ok == OK_HOLD) begin
                if (cnt != 8'hFF)
                    cnt <= cnt + 8'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Outputs follow the next state so routing and FAULT take effect on the transition edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem.ok        <= OK_READY;
            mem.in_data   <= '0;
            mem.bus_exc   <= '0;
            mem1.opm      <= '0;
            mem1.out_data <= '0;
            mem1.addr_a   <= '0;
            mem1.addr_b   <= '0;
            mem2.opm      <= '0;
            mem2.out_data <= '0;
            mem2.addr_a   <= '0;
            mem2.addr_b   <= '0;
        end else begin
            mem.bus_exc   <= exc_nxt;
            mem.ok        <= OK_READY;
            mem.in_data   <= '0;
            mem1.opm      <= '0;
            mem1.out_data <= '0;
            mem1.addr_a   <= '0;
            mem1.addr_b   <= '0;
            mem2.opm      <= '0;
            mem2.out_data <= '0;
            mem2.addr_a   <= '0;
            mem2.addr_b   <= '0;
            unique case (state_nxt)
                FWD1: begin
                    mem1.opm      <= up_opm;
                    mem1.out_data <= up_out_data;
                    mem1.addr_a   <= up_addr_a;
                    mem1.addr_b   <= up_addr_b;
                    mem.ok        <= t1_ok;
                    mem.in_data   <= t1_in_data;
                end
                FWD2: begin
                    mem2.opm      <= up_opm;
                    mem2.out_data <= up_out_data;
                    mem2.addr_a   <= up_addr_a;
                    mem2.addr_b   <= up_addr_b;
                    mem.ok        <= t2_ok;
                    mem.in_data   <= t2_in_data;
                end
                TOUT:    mem.ok <= OK_FAULT;
                default: mem.ok <= OK_READY;
            endcase
        end
    end
endmodule
